// File: rtl/counter_udg_n.sv
// Up/down counter with binary or Gray output encoding, saturate-or-wrap end-of-range
// handling, synchronous load, combinational terminal count and a registered wrap pulse.
module counter_udg_n #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MaxIdx = '1;
  localparam logic [WIDTH-1:0] OneIdx = WIDTH'(1);

  logic [WIDTH-1:0] idx_q, idx_d;
  logic             wrap_q, wrap_d;
  logic             down;
  logic             gray;
  logic             at_end;

  assign down = mode[0];
  assign gray = mode[1];

  // End of range depends on the current direction only, not on en.
  assign at_end = down ? (idx_q == '0) : (idx_q == MaxIdx);

  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (load) begin
      idx_d = load_val;
    end else if (en) begin
      if (!(at_end && sat)) begin
        idx_d  = down ? (idx_q - OneIdx) : (idx_q + OneIdx);
        wrap_d = at_end;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
    end
  end

  // Encoding is a pure output view; idx is never converted.
  assign count = gray ? (idx_q ^ (idx_q >> 1)) : idx_q;
  assign tc    = at_end;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_counter_udg_n.sv
// Directed bench for counter_udg_n (WIDTH=3) with hand-computed expectations.
module tb_counter_udg_n;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       sat;
  logic       load;
  logic [2:0] load_val;
  logic [2:0] count;
  logic       tc;
  logic       wrap;

  int n_vec;
  int n_err;

  counter_udg_n #(
    .WIDTH(3)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .sat     (sat),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .tc      (tc),
    .wrap    (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [2:0] v);
    load     = 1'b1;
    load_val = v;
    step();
    load = 1'b0;
  endtask

  int exp_up [9]  = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
  int exp_gr [8]  = '{1, 3, 2, 6, 7, 5, 4, 0};
  int exp_dn [4]  = '{1, 0, 0, 0};
  logic [2:0] prev;

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    en       = 1'b1;
    mode     = 2'b00;
    sat      = 1'b0;
    load     = 1'b1;
    load_val = 3'd5;
    #1;
    check("rst_count", int'(count), 0);
    check("rst_wrap", int'(wrap), 0);
    check("rst_tc_up", int'(tc), 0);
    mode = 2'b01;
    #1;
    check("rst_tc_dn", int'(tc), 1);
    mode = 2'b11;
    #1;
    check("rst_count_gray", int'(count), 0);
    mode = 2'b00;
    // load and en must be ignored while reset is held
    step();
    step();
    check("rst_hold", int'(count), 0);
    load  = 1'b0;
    reset = 1'b0;

    // Binary up count with wrap
    for (int i = 0; i < 9; i++) begin
      step();
      check($sformatf("up_count[%0d]", i), int'(count), exp_up[i]);
      check($sformatf("up_tc[%0d]", i), int'(tc), (exp_up[i] == 7) ? 1 : 0);
      check($sformatf("up_wrap[%0d]", i), int'(wrap), (i == 7) ? 1 : 0);
    end

    // Gray up count, one bit change per step
    reset = 1'b1;
    #1;
    reset = 1'b0;
    mode  = 2'b10;
    prev  = count;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("gray_count[%0d]", i), int'(count), exp_gr[i]);
      check($sformatf("gray_ham[%0d]", i), $countones(count ^ prev), 1);
      prev = count;
    end

    // Saturating down count from 2
    mode = 2'b01;
    sat  = 1'b1;
    do_load(3'd2);
    check("ld_val", int'(count), 2);
    check("ld_wrap", int'(wrap), 0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("sat_count[%0d]", i), int'(count), exp_dn[i]);
      check($sformatf("sat_tc[%0d]", i), int'(tc), (exp_dn[i] == 0) ? 1 : 0);
      check($sformatf("sat_wrap[%0d]", i), int'(wrap), 0);
    end

    // Down wrap 0 -> 7, then direction change
    sat = 1'b0;
    step();
    check("dn_wrap_count", int'(count), 7);
    check("dn_wrap_pulse", int'(wrap), 1);
    step();
    check("dn_after_count", int'(count), 6);
    check("dn_after_wrap", int'(wrap), 0);
    mode = 2'b00;
    step();
    check("dir_change", int'(count), 7);

    // Hold with en=0, then encoding switch without stepping
    en = 1'b0;
    do_load(3'd5);
    check("ld5", int'(count), 5);
    step();
    check("hold_count", int'(count), 5);
    check("hold_wrap", int'(wrap), 0);
    mode = 2'b10;
    #1;
    check("gray_view", int'(count), 7);
    mode = 2'b00;
    #1;
    check("idx_unchanged", int'(count), 5);
    mode = 2'b10;
    en   = 1'b1;
    step();
    check("gray_step", int'(count), 5);
    mode = 2'b00;
    #1;
    check("gray_step_bin", int'(count), 6);

    // Load beats count
    do_load(3'd3);
    check("ld3", int'(count), 3);
    do_load(3'd6);
    check("ld_prio", int'(count), 6);
    step();
    check("ld_then_up", int'(count), 7);
    check("ld_then_tc", int'(tc), 1);

    // Async reset at max between edges: no pending wrap
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_wrap", int'(wrap), 0);
    step();
    check("rst_held_count", int'(count), 0);
    check("rst_held_wrap", int'(wrap), 0);
    reset = 1'b0;
    step();
    check("post_rst_count", int'(count), 1);
    check("post_rst_wrap", int'(wrap), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_udg_n.md
COUNTER_UDG_N -- requirements
Module: counter_udg_n

Interface
REQ-001 SHALL have parameter: WIDTH, 3, counter width in bits (legal range 2..16).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: en  input  1  count enable.
REQ-005 SHALL have port: mode  input  2  bit0 = direction (0 up, 1 down); bit1 = encoding (0 binary, 1 Gray).
REQ-006 SHALL have port: sat  input  1  1 = saturate at end of range, 0 = wrap.
REQ-007 SHALL have port: load  input  1  synchronous load strobe.
REQ-008 SHALL have port: load_val  input  WIDTH  value to load, binary index.
REQ-009 SHALL have port: count  output  WIDTH  counter value in the encoding selected by mode[1].
REQ-010 SHALL have port: tc  output  1  terminal count, combinational.
REQ-011 SHALL have port: wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-012 SHALL hold a WIDTH-bit binary index register idx; all stepping SHALL be done on idx.
REQ-013 count SHALL equal idx when mode[1]=0, and idx ^ (idx >> 1) when mode[1]=1.
REQ-014 count SHALL follow mode[1] combinationally, with no change to idx.
REQ-015 load=1 SHALL set idx <= load_val on the next edge, regardless of en, sat or mode.
REQ-016 Load SHALL take priority over counting, and wrap SHALL be 0 on a load cycle.
REQ-017 With load=0 and en=0, idx SHALL hold its value and wrap SHALL be 0 on the next cycle.
REQ-018 With load=0, en=1 and mode[0]=0, idx SHALL step idx+1 mod 2^WIDTH.
REQ-019 With load=0, en=1 and mode[0]=1, idx SHALL step idx-1 mod 2^WIDTH.
REQ-020 End of range SHALL be idx = 2^WIDTH-1 when counting up, and idx = 0 when counting down.
REQ-021 tc SHALL be 1 when idx is at the end of range for the current mode[0], independent of en.
REQ-022 At end of range with en=1 and sat=0, idx SHALL wrap (max->0 up, 0->max down) and wrap SHALL be 1 for exactly the following cycle.
REQ-023 At end of range with en=1 and sat=1, idx SHALL hold and wrap SHALL stay 0.
REQ-024 A direction change SHALL take effect on the very next enabled edge, with no extra step and no skipped value.
REQ-025 In Gray mode, successive enabled non-saturated steps (including wrap) SHALL change exactly one bit of count.
REQ-026 Latency from an enabled edge to the updated count SHALL be zero cycles: count changes at that edge.

Reset
REQ-027 reset=1 SHALL immediately force idx=0 and wrap=0, without waiting for a clock edge.
REQ-028 While reset=1, idx and wrap SHALL stay 0; load and en SHALL be ignored.
REQ-029 After reset, count SHALL be 0 in both encodings, and tc SHALL be 1 if mode[0]=1, else 0.
REQ-030 Counting SHALL resume on the first rising edge after reset falls.
REQ-031 Reset asserted mid-count SHALL clear all state and SHALL NOT leave any pending wrap pulse.

Verification
REQ-032 WIDTH=3, mode=00, en=1, sat=0, 9 edges from reset: count 1,2,...,7,0,1; tc=1 while count=7; wrap=1 only in the cycle count=0.
REQ-033 WIDTH=3, mode=10, en=1, 8 edges from reset: count 001,011,010,110,111,101,100,000; every step has Hamming distance 1.
REQ-034 WIDTH=3, mode=01, sat=1, load_val=2 loaded, 4 edges: count 1,0,0,0; tc=1 from count=0; wrap stays 0.
REQ-035 WIDTH=3, idx=5: switch mode[1] 0->1 with en=0: count changes 101->111 immediately, idx unchanged; a following up step gives 110.
REQ-036 load=1 with en=1 at idx=3, load_val=6: next count 6, no +1 step applied; a following up step gives 7 with tc=1.
REQ-037 Assert reset between edges at idx=7, sat=0, up: count=0 and wrap=0 before the next edge; no wrap pulse after reset release.
